jpeg_ff_stuffer: RTL and testbench

JPEG_FF_STUFFER -- requirements
Module: jpeg_ff_stuffer

---
 rtl/jpeg_ff_stuffer.sv | 204 ++++++++++++++++++++
 tb/tb_jpeg_ff_stuffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_ff_stuffer.sv
// JPEG entropy-stream byte stuffer: buffers 32-bit Huffman words, emits them MSB-first
// as bytes, inserts 0x00 after every 0xFF, pads the final word with 1s and appends EOI.
module jpeg_ff_stuffer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    input  logic        in_last,
    input  logic [5:0]  in_bits,
    output logic        in_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        out_ready,
    output logic        scan_done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BYTE   = 3'd1,
        STUFF  = 3'd2,
        EOI_FF = 3'd3,
        EOI_D9 = 3'd4
    } state_t;

    logic [38:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;

    state_t        state_r;
    logic [31:0]   word_r;
    logic          last_r;
    logic [2:0]    nbytes_r;
    logic [1:0]    idx_r;
    logic [7:0]    byte_out_r;
    logic          byte_valid_r;
    logic          scan_done_r;

    logic          push_s;
    logic          pop_s;
    logic          hs_s;
    logic          adv_s;
    logic          fifo_empty_s;
    logic          word_done_s;
    logic [38:0]   head_s;
    logic [31:0]   load_word_s;
    logic [2:0]    load_nbytes_s;

    function automatic logic [5:0] eff_bits(input logic [5:0] bits);
        if (bits == 6'd0 || bits > 6'd32) begin
            eff_bits = 6'd32;
        end else begin
            eff_bits = bits;
        end
    endfunction

    // Final word: every bit below the valid ones becomes 1 (only the last emitted byte matters).
    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic last, input logic [5:0] bits);
        if (last) begin
            pad_word = w | (32'hFFFF_FFFF >> eff_bits(bits));
        end else begin
            pad_word = w;
        end
    endfunction

    function automatic logic [2:0] byte_count(input logic last, input logic [5:0] bits);
        logic [5:0] t;
        t = eff_bits(bits) + 6'd7;
        if (last) begin
            byte_count = t[5:3];
        end else begin
            byte_count = 3'd4;
        end
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = w[31:24];
            2'd1:    byte_sel = w[23:16];
            2'd2:    byte_sel = w[15:8];
            2'd3:    byte_sel = w[7:0];
            default: byte_sel = 8'h00;
        endcase
    endfunction

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(FIFO_DEPTH - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = p + AW'(1);
        end
    endfunction

    assign in_ready      = (count_r < (AW + 1)'(FIFO_DEPTH));
    assign push_s        = data_valid & in_ready;
    assign fifo_empty_s  = (count_r == '0);
    assign hs_s          = byte_valid_r & out_ready;
    assign word_done_s   = ({1'b0, idx_r} == (nbytes_r - 3'd1));
    assign head_s        = mem_r[rd_ptr_r];
    assign load_word_s   = pad_word(head_s[38:7], head_s[6], head_s[5:0]);
    assign load_nbytes_s = byte_count(head_s[6], head_s[5:0]);

    // Decide whether the current data byte is finished and whether the head word is consumed.
    always_comb begin
        adv_s = 1'b0;
        case (state_r)
            BYTE:    adv_s = hs_s && (byte_out_r != 8'hFF);
            STUFF:   adv_s = hs_s;
            default: adv_s = 1'b0;
        endcase
        if (state_r == IDLE) begin
            pop_s = !fifo_empty_s;
        end else begin
            pop_s = adv_s && word_done_s && !last_r && !fifo_empty_s;
        end
    end

    // Input FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {data_in, in_last, in_bits};
        end
    end

    // Input FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Output sequencer: byte emission, stuffing and EOI marker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            word_r       <= 32'h0;
            last_r       <= 1'b0;
            nbytes_r     <= 3'd0;
            idx_r        <= 2'd0;
            byte_out_r   <= 8'h00;
            byte_valid_r <= 1'b0;
            scan_done_r  <= 1'b0;
        end else begin
            scan_done_r <= 1'b0;
            if (pop_s) begin
                // Covers both the IDLE start and the bubble-free word-to-word hand-off.
                word_r       <= load_word_s;
                last_r       <= head_s[6];
                nbytes_r     <= load_nbytes_s;
                idx_r        <= 2'd0;
                byte_out_r   <= load_word_s[31:24];
                byte_valid_r <= 1'b1;
                state_r      <= BYTE;
            end else if (state_r == BYTE && hs_s && byte_out_r == 8'hFF) begin
                byte_out_r <= 8'h00;
                state_r    <= STUFF;
            end else if (adv_s && !word_done_s) begin
                idx_r      <= idx_r + 2'd1;
                byte_out_r <= byte_sel(word_r, idx_r + 2'd1);
                state_r    <= BYTE;
            end else if (adv_s && last_r) begin
                byte_out_r <= 8'hFF;
                state_r    <= EOI_FF;
            end else if (adv_s) begin
                byte_out_r   <= 8'h00;
                byte_valid_r <= 1'b0;
                state_r      <= IDLE;
            end else if (state_r == EOI_FF && hs_s) begin
                byte_out_r <= 8'hD9;
                state_r    <= EOI_D9;
            end else if (state_r == EOI_D9 && hs_s) begin
                byte_out_r   <= 8'h00;
                byte_valid_r <= 1'b0;
                scan_done_r  <= 1'b1;
                state_r      <= IDLE;
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign byte_out   = byte_out_r;
    assign byte_valid = byte_valid_r;
    assign scan_done  = scan_done_r;

endmodule

// File: tb/tb_jpeg_ff_stuffer.sv
// Scoreboard bench for jpeg_ff_stuffer: a byte-level model fills an expected queue,
// a negedge monitor pops and compares on every output handshake.
module tb_jpeg_ff_stuffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_valid;
    logic        in_last;
    logic [5:0]  in_bits;
    logic        in_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        out_ready;
    logic        scan_done;

    typedef struct {
        logic [7:0] b;
        bit         marker;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         hs_count = 0;
    int         done_seen = 0;
    int         done_exp = 0;
    bit         done_next = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    bit         rand_ready = 1'b0;

    always #5 clk = ~clk;

    jpeg_ff_stuffer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .in_last    (in_last),
        .in_bits    (in_bits),
        .in_ready   (in_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .out_ready  (out_ready),
        .scan_done  (scan_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the byte sequence a word must produce on the wire.
    function automatic void model_word(input logic [31:0] w, input bit last, input logic [5:0] bits);
        int b, n, pad;
        logic [7:0] v;
        exp_t e;
        b = (last && bits != 6'd0) ? int'(bits) : 32;
        n = last ? (b + 7) / 8 : 4;
        for (int k = 0; k < n; k++) begin
            v = w[31 - 8 * k -: 8];
            if (last && k == n - 1) begin
                pad = 8 * n - b;
                v = v | 8'((1 << pad) - 1);
            end
            e.b = v; e.marker = 1'b0;
            exp_q.push_back(e);
            if (v == 8'hFF) begin
                e.b = 8'h00;
                exp_q.push_back(e);
            end
        end
        if (last) begin
            e.b = 8'hFF; e.marker = 1'b0; exp_q.push_back(e);
            e.b = 8'hD9; e.marker = 1'b1; exp_q.push_back(e);
            done_exp++;
        end
    endfunction

    // Monitor: compare every accepted byte, hold stability and scan_done timing.
    always @(negedge clk) begin
        if (!rst) begin
            done_next  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("scan_done", scan_done, done_next);
            if (scan_done) done_seen++;
            done_next = 1'b0;
            if (prev_stall) begin
                check("hold_valid", byte_valid, 1);
                check("hold_byte", byte_out, prev_byte);
            end
            if (byte_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_byte: got %0h expected none at %0t", byte_out, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("byte", byte_out, mon_e.b);
                    done_next = mon_e.marker;
                end
                hs_count++;
            end
            prev_stall = byte_valid && !out_ready;
            prev_byte  = byte_out;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_word(input logic [31:0] w, input bit last, input logic [5:0] bits);
        bit ok;
        ok = 1'b0;
        data_in = w; in_last = last; in_bits = bits; data_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 at %0t", $time);
        end else begin
            model_word(w, last, bits);
        end
        @(posedge clk);
        #1 data_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !byte_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain: got %0d bytes pending valid=%0b expected 0 and 0", exp_q.size(), byte_valid);
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words [6];
    int          accepted;
    int          base;
    bit          hit;
    logic [31:0] w;
    bit          last;
    logic [5:0]  bits;

    initial begin
        rst = 1'b0; data_in = 32'h0; data_valid = 1'b0; in_last = 1'b0; in_bits = 6'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", byte_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_done", scan_done, 0);
        check("rst_byte", byte_out, 8'h00);
        @(posedge clk);
        #1 rst = 1'b1;

        send_word(32'h12345678, 1'b0, 6'd0);
        wait_drain();
        send_word(32'hFF00FFAB, 1'b0, 6'd0);
        wait_drain();
        send_word(32'hA5000000, 1'b1, 6'd3);
        wait_drain();
        send_word(32'hFE000000, 1'b1, 6'd7);
        wait_drain();

        // Backpressure: fill working register plus FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) words[i] = 32'h10203040 + 32'h01010101 * i;
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            data_in = words[accepted]; in_last = 1'b0; in_bits = 6'd0; data_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                model_word(words[accepted], 1'b0, 6'd0);
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
        check("accepted", accepted, 5);
        @(negedge clk);
        check("full_ready", in_ready, 0);
        check("stall_valid", byte_valid, 1);
        check("stall_byte", byte_out, 8'h10);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("no_gap", byte_valid, 1);
        end
        wait_drain();

        // Randomized stream with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < 4; k++) begin
                w[31 - 8 * k -: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            end
            last = ($urandom_range(0, 4) == 0);
            bits = 6'($urandom_range(1, 32));
            if ($urandom_range(0, 7) == 0) bits = 6'd0;
            send_word(w, last, bits);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();

        // Mid-word reset.
        base = hs_count;
        send_word(32'h55667788, 1'b0, 6'd0);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (hs_count >= base + 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("reset_point", hit, 1);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_valid", byte_valid, 0);
        check("midrst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send_word(32'h11223344, 1'b0, 6'd0);
        wait_drain();

        check("scan_done_count", done_seen, done_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
